fx2_fifo_sched: RTL and testbench

- Sequences the FX2 slave-FIFO bus and shares it between two requesters:
  - the RX path, which drains EP2 (OUT, host to FPGA);
  - the TX path, which fills EP6 (IN, FPGA to host, e.g. PMC4420 sample stream).
- Owns FIFOADR/SLOE/SLRD/SLWR/PKTEND and the FD output enable.
- Round-robin between RX and TX with bounded bursts.
- Commits short IN packets via PKTEND after a TX idle timeout.

---
 rtl/fx2_fifo_sched.sv | 192 +++++++++++++++++++
 tb/tb_fx2_fifo_sched.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_sched.sv
// FX2 slave-FIFO bus sequencer: shares the bus between the EP2 reader (RX) and the
// EP6 writer (TX) with bounded round-robin bursts, and commits short IN packets on idle.
module fx2_fifo_sched #(
    parameter int unsigned PKT_SIZE     = 512,
    parameter int unsigned MAX_BURST    = 64,
    parameter int unsigned IDLE_TIMEOUT = 4096,
    parameter logic [1:0]  ADDR_RX      = 2'b00,
    parameter logic [1:0]  ADDR_TX      = 2'b10
) (
    input  logic       sys_clk,
    input  logic       RESET,
    input  logic       flag_ep2_empty,
    input  logic       flag_ep6_full,
    output logic       SLOE,
    output logic       SLRD,
    output logic       SLWR,
    output logic [1:0] FIFOADR,
    output logic       PKTEND,
    input  logic [7:0] FDI,
    output logic [7:0] FDO,
    output logic       fd_drive,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    localparam int unsigned ByteW  = (PKT_SIZE > 1) ? $clog2(PKT_SIZE) : 1;
    localparam int unsigned IdleW  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
    localparam logic [ByteW-1:0]  ByteLast = ByteW'(PKT_SIZE - 1);
    localparam logic [IdleW-1:0]  IdleLast = IdleW'(IDLE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StTurn, StRdCheck, StRdStrobe, StWrCheck, StWrStrobe, StPePulse
    } state_e;

    typedef enum logic [1:0] {GntRx, GntTx, GntPe} grant_e;

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    logic              last_tx_q, last_tx_d;
    logic [1:0]        fifoadr_q, fifoadr_d;
    logic [BurstW-1:0] burst_q, burst_d;
    logic [ByteW-1:0]  byte_q, byte_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [7:0]        fdo_q, fdo_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rxc, txc, pec;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_tx_d  = last_tx_q;
        fifoadr_d  = fifoadr_q;
        burst_d    = burst_q;
        byte_d     = byte_q;
        fdo_d      = fdo_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        SLOE       = 1'b1;
        SLRD       = 1'b1;
        SLWR       = 1'b1;
        PKTEND     = 1'b1;
        fd_drive   = 1'b0;
        tx_ready   = 1'b0;
        rxc        = !flag_ep2_empty && !rx_valid_q;
        txc        = tx_valid && !flag_ep6_full;
        pec        = (idle_q == IdleLast) && (byte_q != '0);

        if (rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // Idle timer only runs while a partial IN packet is pending.
        if (byte_q == '0) begin
            idle_d = '0;
        end else if (idle_q == IdleLast) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (pec) begin
                    grant_d   = GntPe;
                    fifoadr_d = ADDR_TX;
                    last_tx_d = 1'b1;
                    burst_d   = '0;
                    state_d   = StTurn;
                end else if (rxc && (!txc || last_tx_q)) begin
                    grant_d   = GntRx;
                    fifoadr_d = ADDR_RX;
                    last_tx_d = 1'b0;
                    burst_d   = '0;
                    state_d   = StTurn;
                end else if (txc) begin
                    grant_d   = GntTx;
                    fifoadr_d = ADDR_TX;
                    last_tx_d = 1'b1;
                    burst_d   = '0;
                    state_d   = StTurn;
                end
            end
            StTurn: begin
                unique case (grant_q)
                    GntRx:   state_d = StRdCheck;
                    GntTx:   state_d = StWrCheck;
                    default: state_d = StPePulse;
                endcase
            end
            StRdCheck: begin
                SLOE = 1'b0;
                if (!flag_ep2_empty && (!rx_valid_q || rx_ready) && (burst_q < BurstMax)) begin
                    state_d = StRdStrobe;
                end else begin
                    state_d = StIdle;
                end
            end
            StRdStrobe: begin
                SLOE       = 1'b0;
                SLRD       = 1'b0;
                rx_data_d  = FDI;
                rx_valid_d = 1'b1;
                burst_d    = burst_q + BurstW'(1);
                state_d    = StRdCheck;
            end
            StWrCheck: begin
                if (tx_valid && !flag_ep6_full && (burst_q < BurstMax)) begin
                    tx_ready = 1'b1;
                    fdo_d    = tx_data;
                    state_d  = StWrStrobe;
                end else begin
                    state_d = StIdle;
                end
            end
            StWrStrobe: begin
                SLWR     = 1'b0;
                fd_drive = 1'b1;
                burst_d  = burst_q + BurstW'(1);
                byte_d   = (byte_q == ByteLast) ? '0 : byte_q + ByteW'(1);
                idle_d   = '0;
                state_d  = StWrCheck;
            end
            StPePulse: begin
                PKTEND  = 1'b0;
                byte_d  = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            grant_q    <= GntRx;
            last_tx_q  <= 1'b1;
            fifoadr_q  <= ADDR_RX;
            burst_q    <= '0;
            byte_q     <= '0;
            idle_q     <= '0;
            fdo_q      <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_tx_q  <= last_tx_d;
            fifoadr_q  <= fifoadr_d;
            burst_q    <= burst_d;
            byte_q     <= byte_d;
            idle_q     <= idle_d;
            fdo_q      <= fdo_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign FIFOADR  = fifoadr_q;
    assign FDO      = fdo_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fx2_fifo_sched.sv
// Scoreboard bench for fx2_fifo_sched: an FX2 endpoint model feeds EP2 and absorbs EP6,
// while a negedge monitor checks bytes, grants, packet commits and bus invariants.
module tb_fx2_fifo_sched;

    localparam int PktSize = 32;
    localparam int MaxBurst = 4;
    localparam int IdleTo = 16;
    localparam logic [1:0] ARx = 2'b00;
    localparam logic [1:0] ATx = 2'b10;

    logic       sys_clk = 1'b0;
    logic       RESET;
    logic       flag_ep2_empty, flag_ep6_full;
    logic       SLOE, SLRD, SLWR, PKTEND, fd_drive;
    logic [1:0] FIFOADR;
    logic [7:0] FDI, FDO, rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, busy;

    fx2_fifo_sched #(
        .PKT_SIZE    (PktSize),
        .MAX_BURST   (MaxBurst),
        .IDLE_TIMEOUT(IdleTo),
        .ADDR_RX     (ARx),
        .ADDR_TX     (ATx)
    ) dut (
        .sys_clk       (sys_clk),
        .RESET         (RESET),
        .flag_ep2_empty(flag_ep2_empty),
        .flag_ep6_full (flag_ep6_full),
        .SLOE          (SLOE),
        .SLRD          (SLRD),
        .SLWR          (SLWR),
        .FIFOADR       (FIFOADR),
        .PKTEND        (PKTEND),
        .FDI           (FDI),
        .FDO           (FDO),
        .fd_drive      (fd_drive),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0] addr;
        int         nrd;
        int         nwr;
        int         npe;
    } grant_t;

    logic [7:0] ep2_q[$], exp_rx[$], tx_src[$], exp_tx[$];
    grant_t     exp_g[$];

    int n_pass = 0, n_total = 0;
    bit rx_rand = 0, rx_hold = 1, full_rand = 0, full_force = 0;
    bit chk_grants = 0, tight_pe = 1;
    bit rd_pend = 0, tx_pend = 0;
    int cyc = 0, last_wr_cyc = 0, ep6_cnt = 0, wr_total = 0;

    bit         in_grant = 0;
    grant_t     cur, m_g;
    bit         m_have, m_ok;
    logic [7:0] m_e;
    int         m_gap;

    int n, w0, wbase;
    bit quiet, found;

    task automatic chk(input string name, input bit ok, input longint act, input longint req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endtask

    function automatic int enc(input grant_t g);
        return int'(g.addr) * 1000 + g.nrd * 100 + g.nwr * 10 + g.npe;
    endfunction

    task automatic push_rx(input logic [7:0] b);
        ep2_q.push_back(b);
        exp_rx.push_back(b);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_src.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic exp_grant(input logic [1:0] a, input int r, input int w, input int p);
        grant_t g;
        g = '{a, r, w, p};
        exp_g.push_back(g);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while ((ep2_q.size() != 0 || tx_src.size() != 0 || exp_rx.size() != 0 || busy)
               && k < limit) begin
            @(negedge sys_clk);
            k++;
        end
        chk(name, k < limit, k, limit);
    endtask

    task automatic settle(input string name);
        wait_drain({name, "_drain"}, 800);
        repeat (IdleTo * 3) @(negedge sys_clk);
        chk({name, "_commit"}, ep6_cnt == 0, ep6_cnt, 0);
        chk({name, "_grants_left"}, exp_g.size() == 0, exp_g.size(), 0);
    endtask

    // FX2 endpoint model: applies strobes seen last cycle, then presents flags and data.
    always @(posedge sys_clk) begin
        #1;
        if (rd_pend && ep2_q.size() != 0) ep2_q.delete(0);
        if (tx_pend && tx_src.size() != 0) tx_src.delete(0);
        rd_pend        = 0;
        tx_pend        = 0;
        flag_ep2_empty = (ep2_q.size() == 0);
        FDI            = (ep2_q.size() != 0) ? ep2_q[0] : 8'h00;
        tx_valid       = (tx_src.size() != 0);
        tx_data        = (tx_src.size() != 0) ? tx_src[0] : 8'h00;
        rx_ready       = rx_rand ? 1'($urandom_range(0, 1)) : rx_hold;
        flag_ep6_full  = full_rand ? ($urandom_range(0, 3) == 0) : full_force;
    end

    always @(negedge sys_clk) begin
        cyc++;
        if (!RESET) begin
            in_grant = 0;
        end else begin
            if (busy && !in_grant) begin
                in_grant = 1;
                cur = '{FIFOADR, 0, 0, 0};
            end
            m_ok = !(fd_drive && !SLOE) && (fd_drive == !SLWR) && !(tx_ready && flag_ep6_full)
                   && (SLRD || SLWR) && (SLRD || (FIFOADR == ARx && !SLOE))
                   && (SLWR || FIFOADR == ATx);
            chk("bus_invariant", m_ok,
                {SLOE, SLRD, SLWR, PKTEND, fd_drive, tx_ready, flag_ep6_full, FIFOADR}, 0);
            if (!SLRD) begin
                rd_pend = 1;
                cur.nrd++;
            end
            if (rx_valid && rx_ready) begin
                m_have = exp_rx.size() != 0;
                m_e = m_have ? exp_rx[0] : 8'h00;
                if (m_have) exp_rx.delete(0);
                chk("rx_data", m_have && rx_data == m_e, rx_data, m_e);
            end
            if (tx_ready) tx_pend = 1;
            if (!SLWR) begin
                m_have = exp_tx.size() != 0;
                m_e = m_have ? exp_tx[0] : 8'h00;
                if (m_have) exp_tx.delete(0);
                chk("ep6_byte", m_have && FDO == m_e, FDO, m_e);
                ep6_cnt = (ep6_cnt + 1) % PktSize;
                last_wr_cyc = cyc;
                wr_total++;
                cur.nwr++;
            end
            if (!PKTEND) begin
                m_gap = cyc - last_wr_cyc;
                chk("pktend_nonempty", ep6_cnt != 0 && FIFOADR == ATx, ep6_cnt, 1);
                chk("pktend_gap_min", m_gap >= IdleTo, m_gap, IdleTo);
                if (tight_pe) chk("pktend_gap_max", m_gap <= IdleTo + 2, m_gap, IdleTo + 2);
                ep6_cnt = 0;
                cur.npe++;
            end
            if (!busy && in_grant) begin
                in_grant = 0;
                chk("burst_len", cur.nrd + cur.nwr <= MaxBurst, cur.nrd + cur.nwr, MaxBurst);
                if (chk_grants) begin
                    m_have = exp_g.size() != 0;
                    m_g = m_have ? exp_g[0] : '{2'b11, 9, 9, 9};
                    if (m_have) exp_g.delete(0);
                    chk("grant_seq", m_have && enc(cur) == enc(m_g), enc(cur), enc(m_g));
                end
            end
        end
    end

    initial begin
        RESET = 1'b0;
        flag_ep2_empty = 1'b1;
        flag_ep6_full = 1'b0;
        FDI = 8'h00;
        rx_ready = 1'b1;
        tx_data = 8'h00;
        tx_valid = 1'b0;
        #12;
        chk("rst_SLOE", SLOE === 1'b1, SLOE, 1);
        chk("rst_SLRD", SLRD === 1'b1, SLRD, 1);
        chk("rst_SLWR", SLWR === 1'b1, SLWR, 1);
        chk("rst_PKTEND", PKTEND === 1'b1, PKTEND, 1);
        chk("rst_FIFOADR", FIFOADR === ARx, FIFOADR, ARx);
        chk("rst_FDO", FDO === 8'h00, FDO, 0);
        chk("rst_fd_drive", fd_drive === 1'b0, fd_drive, 0);
        chk("rst_rx_valid", rx_valid === 1'b0, rx_valid, 0);
        chk("rst_tx_ready", tx_ready === 1'b0, tx_ready, 0);
        chk("rst_busy", busy === 1'b0, busy, 0);
        @(negedge sys_clk);
        RESET = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Three bytes from EP2 in one RX grant.
        chk_grants = 1;
        exp_grant(ARx, 3, 0, 0);
        push_rx(8'hA1);
        push_rx(8'hB2);
        push_rx(8'hC3);
        settle("rx3");

        // Five TX bytes, then a short packet committed on timeout.
        exp_grant(ATx, 0, 4, 0);
        exp_grant(ATx, 0, 1, 0);
        exp_grant(ATx, 0, 0, 1);
        for (int i = 0; i < 5; i++) push_tx(8'($urandom));
        settle("tx5");

        // Exactly one packet: auto-committed, no PKTEND.
        for (int i = 0; i < PktSize / MaxBurst; i++) exp_grant(ATx, 0, MaxBurst, 0);
        for (int i = 0; i < PktSize; i++) push_tx(8'($urandom));
        settle("wrap");

        // Both sides pending: grants alternate starting with RX.
        for (int i = 0; i < 2; i++) begin
            exp_grant(ARx, MaxBurst, 0, 0);
            exp_grant(ATx, 0, MaxBurst, 0);
        end
        exp_grant(ATx, 0, 0, 1);
        for (int i = 0; i < 2 * MaxBurst; i++) begin
            push_rx(8'($urandom));
            push_tx(8'($urandom));
        end
        settle("alt");

        // EP6 full mid-stream stalls writes with the bus released.
        chk_grants = 0;
        tight_pe = 0;
        wbase = wr_total;
        for (int i = 0; i < 12; i++) push_tx(8'($urandom));
        n = 0;
        while (wr_total < wbase + 6 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        chk("full_reach6", n < 200, n, 200);
        full_force = 1;
        @(posedge sys_clk);
        #2;
        w0 = wr_total;
        repeat (2) @(negedge sys_clk);
        quiet = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (!SLWR || tx_ready || fd_drive || !SLOE) quiet = 0;
        end
        chk("full_quiet", quiet, {SLWR, tx_ready, fd_drive, SLOE}, 1);
        chk("full_stall", wr_total - w0 <= 1, wr_total - w0, 1);
        @(negedge sys_clk);
        full_force = 0;
        settle("full");

        // Reset in RD_STROBE, then RX wins the first tie after release.
        chk_grants = 1;
        tight_pe = 1;
        for (int i = 0; i < 3; i++) push_rx(8'($urandom));
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            @(posedge sys_clk);
            #1;
            found = (SLRD == 1'b0);
            n++;
        end
        chk("rdstrobe_seen", found, n, 40);
        RESET = 1'b0;
        #1;
        chk("rst_mid_SLRD", SLRD === 1'b1, SLRD, 1);
        chk("rst_mid_SLOE", SLOE === 1'b1, SLOE, 1);
        chk("rst_mid_rx_valid", rx_valid === 1'b0, rx_valid, 0);
        chk("rst_mid_busy", busy === 1'b0, busy, 0);
        @(negedge sys_clk);
        push_tx(8'($urandom));
        push_tx(8'($urandom));
        exp_grant(ARx, 3, 0, 0);
        exp_grant(ATx, 0, 2, 0);
        exp_grant(ATx, 0, 0, 1);
        repeat (2) @(negedge sys_clk);
        RESET = 1'b1;
        settle("rst");

        // Random traffic with random back-pressure.
        chk_grants = 0;
        tight_pe = 0;
        for (int r = 0; r < 6; r++) begin
            @(negedge sys_clk);
            rx_rand = 1;
            full_rand = 1;
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) push_rx(8'($urandom));
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) push_tx(8'($urandom));
            wait_drain("rand_round", 2000);
            rx_rand = 0;
            full_rand = 0;
        end
        settle("rand");
        chk("tx_all_written", exp_tx.size() == 0, exp_tx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
